rx_comando_serial: RTL and testbench



---
 rtl/roberto_pkg.sv | 17 +
 rtl/rx_serial_7E2.sv | 127 ++++++++++++
 rtl/rx_comando_serial.sv | 81 ++++++++
 tb/tb_rx_comando_serial.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/roberto_pkg.sv
// Shared constants and the receiver state encodings used by the hex debug display.
package roberto_pkg;

  localparam int         CLKS_PER_BIT_DEFAULT = 434;
  localparam logic [6:0] ASCII_TERMINADOR     = 7'h23;

  typedef enum logic [3:0] {
    ST_OCIOSO   = 4'd0,
    ST_INICIO   = 4'd1,
    ST_DADOS    = 4'd2,
    ST_PARIDADE = 4'd3,
    ST_STOP1    = 4'd4,
    ST_STOP2    = 4'd5,
    ST_AVALIA   = 4'd6
  } estado_t;

endpackage

// File: rtl/rx_serial_7E2.sv
// 7E2 UART character receiver: 2-flop synchroniser, centre-sampling bit timer, byte FSM.
// dado_ok/dado_erro pulse combinationally on the stop2 sample cycle; no backpressure.
module rx_serial_7E2
  import roberto_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [6:0] dado,
  output logic       dado_ok,
  output logic       dado_erro,
  output logic [3:0] db_estado
);

  localparam int            TW     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_BIT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_sync, rx_prev;
  estado_t       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [2:0]    idx_q, idx_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;
  logic          tick, fim;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_OCIOSO;
      timer_q   <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign tick = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = tick ? '0 : timer_q - 1'b1;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    fim       = 1'b0;
    case (state_q)
      ST_OCIOSO: begin
        timer_d = '0;
        if (rx_prev && !rx_sync) begin
          state_d   = ST_INICIO;
          timer_d   = T_HALF;
          idx_d     = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      ST_INICIO: begin
        // A start bit that is high again at its centre was only a glitch.
        if (tick) begin
          timer_d = T_BIT;
          state_d = rx_sync ? ST_OCIOSO : ST_DADOS;
        end
      end
      ST_DADOS: begin
        if (tick) begin
          shreg_d = {rx_sync, shreg_q[6:1]};
          timer_d = T_BIT;
          if (idx_q == 3'd6) state_d = ST_PARIDADE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_PARIDADE: begin
        if (tick) begin
          par_err_d = ^{rx_sync, shreg_q};
          timer_d   = T_BIT;
          state_d   = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (tick) begin
          frm_err_d = !rx_sync;
          timer_d   = T_BIT;
          state_d   = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (tick) begin
          frm_err_d = frm_err_q | !rx_sync;
          fim       = 1'b1;
          state_d   = ST_AVALIA;
        end
      end
      ST_AVALIA: state_d = ST_OCIOSO;
      default:   state_d = ST_OCIOSO;
    endcase
  end

  assign dado      = shreg_q;
  assign dado_ok   = fim && !par_err_q && !frm_err_d;
  assign dado_erro = fim && (par_err_q || frm_err_d);
  assign db_estado = state_q;

endmodule

// File: rtl/rx_comando_serial.sv
// Serial command receiver: assembles N_CHARS characters ended by '#', pulses pronto or erro in avalia.
// Outputs update on the edge that raises pronto; the serial line cannot be backpressured.
module rx_comando_serial
  import roberto_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int N_CHARS      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [6:0] dado_recebido_1,
  output logic [6:0] dado_recebido_2,
  output logic [6:0] dado_recebido_3,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int           NW    = $clog2(N_CHARS + 1);
  localparam logic [NW-1:0] N_MAX = NW'(N_CHARS);

  logic [6:0]    dado;
  logic          dado_ok, dado_erro;
  logic [6:0]    cmd_buf [N_CHARS];
  logic [NW-1:0] n_q;
  logic          excesso_q;

  rx_serial_7E2 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (RX),
    .dado      (dado),
    .dado_ok   (dado_ok),
    .dado_erro (dado_erro),
    .db_estado (db_estado)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_q             <= '0;
      excesso_q       <= 1'b0;
      pronto          <= 1'b0;
      erro            <= 1'b0;
      dado_recebido_1 <= '0;
      dado_recebido_2 <= '0;
      dado_recebido_3 <= '0;
      for (int i = 0; i < N_CHARS; i++) cmd_buf[i] <= '0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      if (dado_erro) begin
        erro      <= 1'b1;
        n_q       <= '0;
        excesso_q <= 1'b0;
      end else if (dado_ok) begin
        if (dado == ASCII_TERMINADOR) begin
          n_q       <= '0;
          excesso_q <= 1'b0;
          if (n_q == N_MAX && !excesso_q) begin
            pronto          <= 1'b1;
            dado_recebido_1 <= cmd_buf[0];
            dado_recebido_2 <= cmd_buf[1];
            dado_recebido_3 <= cmd_buf[2];
          end else begin
            erro <= 1'b1;
          end
        end else if (n_q < N_MAX) begin
          cmd_buf[n_q] <= dado;
          n_q          <= n_q + 1'b1;
        end else begin
          // Too many characters: remembered so the eventual '#' is rejected.
          excesso_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_comando_serial.sv
// Directed bench for rx_comando_serial with CLKS_PER_BIT=8.
module tb_rx_comando_serial;

  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       RX    = 1'b1;
  logic [6:0] dado_recebido_1, dado_recebido_2, dado_recebido_3;
  logic       pronto, erro;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  int erro_cnt = 0;
  int both_cnt = 0;
  int st_max = 0;

  rx_comando_serial #(
    .CLKS_PER_BIT (CPB),
    .N_CHARS      (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .RX              (RX),
    .dado_recebido_1 (dado_recebido_1),
    .dado_recebido_2 (dado_recebido_2),
    .dado_recebido_3 (dado_recebido_3),
    .pronto          (pronto),
    .erro            (erro),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pronto) pronto_cnt++;
    if (erro) erro_cnt++;
    if (pronto && erro) both_cnt++;
    if (int'(db_estado) > st_max) st_max = int'(db_estado);
  end

  task automatic send_bit(input logic b);
    RX = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_char(input logic [7:0] c, input logic flip_par, input logic stop2);
    logic [6:0] d;
    d = c[6:0];
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    send_bit((^d) ^ flip_par);
    send_bit(1'b1);
    send_bit(stop2);
    RX = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_counts;
    pronto_cnt = 0;
    erro_cnt   = 0;
  endtask

  task automatic check_outs(input string name, input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3);
    checks++;
    if (dado_recebido_1 !== e1) begin errors++; $display("FAIL %s d1: got %h expected %h", name, dado_recebido_1, e1); end
    checks++;
    if (dado_recebido_2 !== e2) begin errors++; $display("FAIL %s d2: got %h expected %h", name, dado_recebido_2, e2); end
    checks++;
    if (dado_recebido_3 !== e3) begin errors++; $display("FAIL %s d3: got %h expected %h", name, dado_recebido_3, e3); end
  endtask

  task automatic check_pulses(input string name, input int ep, input int ee);
    checks++;
    if (pronto_cnt !== ep) begin errors++; $display("FAIL %s pronto count: got %0d expected %0d", name, pronto_cnt, ep); end
    checks++;
    if (erro_cnt !== ee) begin errors++; $display("FAIL %s erro count: got %0d expected %0d", name, erro_cnt, ee); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    check_outs("reset", 7'h00, 7'h00, 7'h00);
    checks++;
    if (pronto !== 1'b0 || erro !== 1'b0) begin errors++; $display("FAIL reset pulses: got %b%b expected 00", pronto, erro); end
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL reset db_estado: got %0d expected 0", db_estado); end
    reset = 1'b0;
    idle(5);
  endtask

  task automatic test_valid;
    clear_counts();
    send_str("ABC#");
    idle(20);
    check_pulses("valid", 1, 0);
    check_outs("valid", 7'h41, 7'h42, 7'h43);
  endtask

  task automatic test_parity;
    clear_counts();
    send_char("X", 1'b1, 1'b1);
    idle(20);
    check_pulses("parity_x", 0, 1);
    clear_counts();
    send_str("123#");
    idle(20);
    check_pulses("parity_after", 1, 0);
    check_outs("parity_after", 7'h31, 7'h32, 7'h33);
  endtask

  task automatic test_length;
    clear_counts();
    send_str("AB#");
    idle(20);
    check_pulses("short", 0, 1);
    check_outs("short", 7'h31, 7'h32, 7'h33);
    clear_counts();
    send_str("ABCD");
    idle(20);
    check_pulses("long_pre", 0, 0);
    send_str("#");
    idle(20);
    check_pulses("long", 0, 1);
    check_outs("long", 7'h31, 7'h32, 7'h33);
  endtask

  task automatic test_framing;
    clear_counts();
    send_char("A", 1'b0, 1'b0);
    idle(20);
    check_pulses("framing", 0, 1);
    clear_counts();
    send_str("DEF#");
    idle(20);
    check_pulses("framing_after", 1, 0);
    check_outs("framing_after", 7'h44, 7'h45, 7'h46);
  endtask

  task automatic test_glitch;
    clear_counts();
    st_max = 0;
    RX = 1'b0;
    repeat (2) @(negedge clock);
    idle(30);
    check_pulses("glitch", 0, 0);
    checks++;
    if (st_max !== 1) begin errors++; $display("FAIL glitch max state: got %0d expected 1", st_max); end
  endtask

  task automatic test_break;
    clear_counts();
    RX = 1'b0;
    repeat (200) @(negedge clock);
    check_pulses("break", 0, 1);
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL break db_estado: got %0d expected 0", db_estado); end
    idle(20);
  endtask

  task automatic test_reset_mid;
    clear_counts();
    send_char("A", 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    #1 reset = 1'b1;
    #2;
    check_outs("rst_mid", 7'h00, 7'h00, 7'h00);
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL rst_mid db_estado: got %0d expected 0", db_estado); end
    RX = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    idle(10);
    check_pulses("rst_mid_pulses", 0, 0);
    send_str("QRS#");
    idle(20);
    check_pulses("rst_mid_after", 1, 0);
    check_outs("rst_mid_after", 7'h51, 7'h52, 7'h53);
  endtask

  initial begin
    test_reset();
    test_valid();
    test_parity();
    test_length();
    test_framing();
    test_glitch();
    test_break();
    test_reset_mid();
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL exclusive pulses: got %0d overlaps expected 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
